// File: rtl/datapath_pkg.sv
// Types shared by the datapath, its sequencer and the assertion checker.
// Defines the 24-bit instruction word layout and the ALU opcode set.
package datapath_pkg;

  localparam int INSTR_W = 24;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_CMP = 3'b010,
    OP_AND = 3'b011,
    OP_MOV = 3'b100,
    OP_NOP = 3'b110
  } op_t;

  typedef enum logic [1:0] {
    K_ALU  = 2'b00,
    K_JMP  = 2'b01,
    K_BRF  = 2'b10,
    K_HALT = 2'b11
  } kind_t;

  // JMP/BRF reuse the low bits of the word as the branch target.
  typedef struct packed {
    kind_t      kind;
    logic [2:0] op;
    logic [3:0] wa;
    logic [3:0] raa;
    logic [3:0] rab;
    logic [3:0] sel;
    logic       wen;
    logic [1:0] rsvd;
  } instr_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the sequencer: single port, synchronous write and read.
// Contents are deliberately not reset so a loaded program survives rst.
module seq_prog_mem #(
  parameter int AW = 5,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Fetch/decode sequencer driving the datapath controls, one instruction per
// two cycles, with conditional branching on the datapath compare flag.
//
// state | meaning
// IDLE  | waiting for start; program memory writable
// FETCH | synchronous program read at pc; controls hold
// EXEC  | decode fetched word, issue controls, update pc and step budget
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int PC_W      = 5,
  parameter int MAX_STEPS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               Flag,
  output logic [3:0]         Sel,
  output logic               Wen,
  output logic [3:0]         WA,
  output logic [3:0]         RAA,
  output logic [3:0]         RAB,
  output logic [2:0]         Op,
  output logic [PC_W-1:0]    pc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(MAX_STEPS - 1);

  logic [1:0]         state;
  logic [INSTR_W-1:0] rdata;
  instr_t             word;
  logic [PC_W-1:0]    target;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_we;
  logic               mem_re;
  logic               issue;
  logic [3:0]         sel_q, wa_q, raa_q, rab_q;
  logic               cmp_pend;
  logic               flag_q;
  logic [STEP_W-1:0]  steps_left;
  logic               unused_rsvd;

  assign busy        = (state != S_IDLE);
  assign mem_we      = prog_we && (state == S_IDLE);
  assign mem_re      = (state == S_FETCH);
  assign mem_addr    = (state == S_IDLE) ? prog_addr : pc;
  assign word        = instr_t'(rdata);
  assign target      = rdata[PC_W-1:0];
  assign issue       = (state == S_EXEC) && (word.kind == K_ALU);
  assign unused_rsvd = ^word.rsvd;

  seq_prog_mem #(
    .AW(PC_W),
    .DW(INSTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(prog_data),
    .rdata(rdata)
  );

  // Fields are live only in the issuing EXEC cycle; otherwise the last issue holds.
  always_comb begin
    Sel = sel_q;
    WA  = wa_q;
    RAA = raa_q;
    RAB = rab_q;
    Wen = 1'b0;
    Op  = OP_NOP;
    if (issue) begin
      Sel = word.sel;
      WA  = word.wa;
      RAA = word.raa;
      RAB = word.rab;
      Op  = word.op;
      Wen = word.wen && (word.op != OP_CMP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      sel_q      <= '0;
      wa_q       <= '0;
      raa_q      <= '0;
      rab_q      <= '0;
      cmp_pend   <= 1'b0;
      flag_q     <= 1'b0;
      steps_left <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_FETCH;
            pc         <= '0;
            steps_left <= STEP_LOAD;
            error      <= 1'b0;
            cmp_pend   <= 1'b0;
          end
        end
        S_FETCH: begin
          state <= S_EXEC;
          // Flag is valid exactly one cycle after the CMP issue.
          if (cmp_pend) begin
            flag_q   <= Flag;
            cmp_pend <= 1'b0;
          end
        end
        S_EXEC: begin
          case (word.kind)
            K_ALU: begin
              pc       <= pc + 1'b1;
              sel_q    <= word.sel;
              wa_q     <= word.wa;
              raa_q    <= word.raa;
              rab_q    <= word.rab;
              cmp_pend <= (word.op == OP_CMP);
            end
            K_JMP:   pc <= target;
            K_BRF:   pc <= flag_q ? target : pc + 1'b1;
            default: ;
          endcase
          if (word.kind == K_HALT) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else if (steps_left == '0) begin
            state <= S_IDLE;
            done  <= 1'b1;
            error <= 1'b1;
          end else begin
            steps_left <= steps_left - 1'b1;
            state      <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: a per-cycle vector table for a short
// ALU program plus hand sequences for branching, abort, write gating and reset.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, prog_we, Flag;
  logic [4:0]  prog_addr;
  logic [23:0] prog_data;
  logic        busy, done, error, Wen;
  logic [3:0]  Sel, WA, RAA, RAB;
  logic [2:0]  Op;
  logic [4:0]  pc;

  localparam logic [23:0] HALT = 24'hC00000;

  always #5 clk = ~clk;

  datapath_sequencer #(.PC_W(5), .MAX_STEPS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .Flag(Flag),
    .Sel(Sel), .Wen(Wen), .WA(WA), .RAA(RAA), .RAB(RAB), .Op(Op), .pc(pc)
  );

  typedef struct packed {
    logic       busy, done, err, wen;
    logic [2:0] op;
    logic [3:0] wa, raa, rab, sel;
    logic [4:0] pc;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t exp;
  } vec_t;

  obs_t smp [0:319];
  vec_t vecs [8];
  int   checks = 0;
  int   errors = 0;
  int   wen_cnt;
  int   n;
  int   done_seen;

  function automatic obs_t mk(input int b, d, e, w, op, wa, raa, rab, sel, p);
    return {1'(b), 1'(d), 1'(e), 1'(w), 3'(op), 4'(wa), 4'(raa), 4'(rab), 4'(sel), 5'(p)};
  endfunction

  function automatic obs_t cur();
    return {busy, done, error, Wen, Op, WA, RAA, RAB, Sel, pc};
  endfunction

  function automatic logic [23:0] alu(input logic [2:0] op, input logic [3:0] wa, raa, rab, sel,
                                     input logic wen);
    return {2'b00, op, wa, raa, rab, sel, wen, 2'b00};
  endfunction

  function automatic logic [23:0] jmp(input logic [4:0] t);
    return {2'b01, 17'd0, t};
  endfunction

  function automatic logic [23:0] brf(input logic [4:0] t);
    return {2'b10, 17'd0, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [23:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  // smp[k] holds outputs during the k-th cycle after the start cycle (k=0).
  // Optional write alongside start; optional start+write injection at k=1.
  task automatic run(input logic w0, input logic [4:0] a0, input logic [23:0] d0,
                     input logic inj, output int nd);
    bit got;
    got     = 0;
    wen_cnt = 0;
    nd      = 299;
    for (int k = 0; k < 300; k++) begin
      smp[k] = cur();
      if (k > 0 && Wen) wen_cnt++;
      if (k > 0 && done) begin
        got = 1;
        nd  = k;
        break;
      end
      start     = (k == 0) || (k == 1 && inj);
      prog_we   = (k == 0 && w0) || (k == 1 && inj);
      prog_addr = (k == 0) ? a0 : 5'd1;
      prog_data = (k == 0) ? d0 : HALT;
      tick();
    end
    start   = 1'b0;
    prog_we = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got no done expected done within 300 cycles");
    end
    tick();
    smp[nd+1] = cur();
  endtask

  initial begin
    vecs[0] = '{1, mk(1, 0, 0, 0, 'b110, 0, 0, 0, 0, 0)};
    vecs[1] = '{2, mk(1, 0, 0, 1, 'b100, 1, 0, 0, 2, 0)};
    vecs[2] = '{3, mk(1, 0, 0, 0, 'b110, 1, 0, 0, 2, 1)};
    vecs[3] = '{4, mk(1, 0, 0, 1, 'b000, 2, 1, 1, 0, 1)};
    vecs[4] = '{5, mk(1, 0, 0, 0, 'b110, 2, 1, 1, 0, 2)};
    vecs[5] = '{6, mk(1, 0, 0, 0, 'b110, 2, 1, 1, 0, 2)};
    vecs[6] = '{7, mk(0, 1, 0, 0, 'b110, 2, 1, 1, 0, 2)};
    vecs[7] = '{8, mk(0, 0, 0, 0, 'b110, 2, 1, 1, 0, 2)};

    rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; Flag = 1'b0;
    tick();
    tick();
    check("reset_state", 32'(cur()), 32'(mk(0, 0, 0, 0, 'b110, 0, 0, 0, 0, 0)));
    rst = 1'b0;

    // MOV / ADD / HALT walked cycle by cycle
    load(5'd0, alu(3'b100, 4'd1, 4'd0, 4'd0, 4'd2, 1'b1));
    load(5'd1, alu(3'b000, 4'd2, 4'd1, 4'd1, 4'd0, 1'b1));
    load(5'd2, HALT);
    run(1'b0, 5'd0, 24'd0, 1'b0, n);
    check("main_done_cycle", 32'(n), 32'd7);
    for (int i = 0; i < 8; i++)
      check($sformatf("main_cycle%0d", vecs[i].cyc), 32'(smp[vecs[i].cyc]), 32'(vecs[i].exp));

    // CMP (Wen bit set in encoding) then BRF to 5
    load(5'd0, alu(3'b010, 4'd0, 4'd1, 4'd2, 4'd0, 1'b1));
    load(5'd1, brf(5'd5));
    load(5'd2, HALT);
    load(5'd5, HALT);
    Flag = 1'b0;
    run(1'b0, 5'd0, 24'd0, 1'b0, n);
    check("brf_f0_done_cycle", 32'(n), 32'd7);
    check("brf_f0_pc", 32'(smp[n].pc), 32'd2);
    check("brf_f0_wen_count", 32'(wen_cnt), 32'd0);
    check("cmp_issue_op_wen", 32'({smp[2].op, smp[2].wen}), 32'({3'b010, 1'b0}));
    Flag = 1'b1;
    run(1'b0, 5'd0, 24'd0, 1'b0, n);
    check("brf_f1_pc", 32'(smp[n].pc), 32'd5);
    check("brf_f1_wen_count", 32'(wen_cnt), 32'd0);

    // pc wrap: BRF on held flag to 31, CMP at 31 wraps to 0 and clears flag
    load(5'd0, brf(5'd31));
    load(5'd31, alu(3'b010, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0));
    load(5'd1, HALT);
    Flag = 1'b0;
    run(1'b0, 5'd0, 24'd0, 1'b0, n);
    check("wrap_pc_at_31", 32'(smp[3].pc), 32'd31);
    check("wrap_pc_to_0", 32'(smp[5].pc), 32'd0);
    check("wrap_done_cycle", 32'(n), 32'd9);
    check("wrap_final_pc", 32'(smp[n].pc), 32'd1);

    // JMP 0 forever: aborted after 8 EXEC cycles
    load(5'd0, jmp(5'd0));
    run(1'b0, 5'd0, 24'd0, 1'b0, n);
    check("abort_done_cycle", 32'(n), 32'd17);
    check("abort_error", 32'(smp[n].err), 32'd1);
    check("abort_after_err_busy_done", 32'({smp[n+1].err, smp[n+1].busy, smp[n+1].done}),
          32'({1'b1, 1'b0, 1'b0}));

    // write with start in the same idle cycle; start + write again while busy
    load(5'd1, alu(3'b011, 4'd4, 4'd3, 4'd3, 4'd0, 1'b1));
    load(5'd2, HALT);
    run(1'b1, 5'd0, alu(3'b100, 4'd3, 4'd0, 4'd0, 4'd5, 1'b1), 1'b1, n);
    check("err_sticky_until_start", 32'(smp[0].err), 32'd1);
    check("err_cleared_by_start", 32'(smp[1].err), 32'd0);
    check("same_cycle_write_seen", 32'({smp[2].wen, smp[2].op, smp[2].wa, smp[2].sel}),
          32'({1'b1, 3'b100, 4'd3, 4'd5}));
    check("busy_write_ignored", 32'({smp[4].wen, smp[4].op, smp[4].wa, smp[4].raa, smp[4].rab}),
          32'({1'b1, 3'b011, 4'd4, 4'd3, 4'd3}));
    check("busy_start_ignored", 32'(n), 32'd7);
    run(1'b0, 5'd0, 24'd0, 1'b0, n);
    check("mem_unchanged_rerun", 32'({smp[4].op, smp[4].wa}), 32'({3'b011, 4'd4}));
    check("mem_unchanged_done", 32'(n), 32'd7);

    // rst during EXEC of a writing ALU
    load(5'd0, alu(3'b100, 4'd1, 4'd0, 4'd0, 4'd2, 1'b1));
    load(5'd1, HALT);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_wen", 32'(Wen), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_outputs", 32'(cur()), 32'(mk(0, 0, 0, 0, 'b110, 0, 0, 0, 0, 0)));
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("mid_rst_no_done", 32'(done_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
